// File: rtl/warp_ctl_receiver.sv
// Warp-control receiver: applies tmc / wspawn / barrier events to per-warp state
// and serialises spawns to the scheduler. Optional perf counters: WARP_CTL_PERF_EN.
module warp_ctl_receiver #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_BARRIERS = 4,
    localparam int NW_BITS     = $clog2(NUM_WARPS),
    localparam int NB_BITS     = $clog2(NUM_BARRIERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctl_valid,
    input  logic [NW_BITS-1:0]     ctl_wid,
    input  logic                   tmc_valid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    input  logic                   wspawn_valid,
    input  logic [NUM_WARPS-1:0]   wspawn_wmask,
    input  logic [31:0]            wspawn_pc,
    input  logic                   bar_valid,
    input  logic [NB_BITS-1:0]     bar_id,
    input  logic [NW_BITS-1:0]     bar_size_m1,
    output logic [NUM_WARPS-1:0]   active_warps,
    output logic [NUM_WARPS-1:0]   stalled_warps,
    input  logic [NW_BITS-1:0]     sched_wid,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic                   spawn_valid,
    output logic [NW_BITS-1:0]     spawn_wid,
    output logic [31:0]            spawn_pc,
    input  logic                   spawn_ready,
    output logic                   wspawn_busy,
    output logic                   spawn_overrun
`ifdef WARP_CTL_PERF_EN
    ,
    output logic [31:0]            perf_bar_stall_cycles,
    output logic [31:0]            perf_spawns
`endif
);

    typedef enum logic {IDLE, SPAWN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_WARPS-1:0]   pend_q, pend_d;
    logic [31:0]            pc_q, pc_d;
    logic                   overrun_q, overrun_d;
    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
    logic [NW_BITS-1:0]     bar_cnt_q [NUM_BARRIERS];
    logic [NW_BITS-1:0]     bar_cnt_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   bar_mask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   bar_mask_d [NUM_BARRIERS];

    logic                   tmc_ev, wspawn_ev, bar_ev;
    logic                   handshake;
    logic                   found;
    logic [NW_BITS-1:0]     low_wid;
    logic [NUM_WARPS-1:0]   new_pend;

    always_comb begin
        tmc_ev    = ctl_valid && tmc_valid;
        wspawn_ev = ctl_valid && !tmc_valid && wspawn_valid;
        bar_ev    = ctl_valid && !tmc_valid && !wspawn_valid && bar_valid;
        handshake = (state_q == SPAWN) && spawn_ready;
    end

    always_comb begin
        low_wid = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            if (pend_q[i] && !found) begin
                low_wid = NW_BITS'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pc_d       = pc_q;
        overrun_d  = overrun_q;
        active_d   = active_q;
        stalled_d  = stalled_q;
        tmask_d    = tmask_q;
        bar_cnt_d  = bar_cnt_q;
        bar_mask_d = bar_mask_q;
        new_pend   = '0;

        // Order matters: spawn's active-set beats a tmc clear, tmc's tmask beats spawn's.
        if (tmc_ev && tmc_tmask == '0) begin
            active_d[ctl_wid] = 1'b0;
        end
        if (handshake) begin
            pend_d[low_wid]   = 1'b0;
            active_d[low_wid] = 1'b1;
            tmask_d[low_wid]  = NUM_THREADS'(1);
        end
        if (tmc_ev) begin
            tmask_d[ctl_wid] = tmc_tmask;
        end

        if (wspawn_ev) begin
            // Mask against active_d so a warp handshaking this cycle is not queued twice.
            new_pend = wspawn_wmask & ~(NUM_WARPS'(1) << ctl_wid) & ~active_d;
            pc_d     = wspawn_pc;
            if (state_q == IDLE) begin
                pend_d = new_pend;
            end else begin
                pend_d    = pend_d | new_pend;
                overrun_d = 1'b1;
            end
        end

        if (bar_ev) begin
            if (bar_cnt_q[bar_id] == bar_size_m1) begin
                stalled_d          = stalled_d & ~bar_mask_q[bar_id];
                bar_cnt_d[bar_id]  = '0;
                bar_mask_d[bar_id] = '0;
            end else begin
                bar_cnt_d[bar_id]           = bar_cnt_q[bar_id] + NW_BITS'(1);
                bar_mask_d[bar_id][ctl_wid] = 1'b1;
                stalled_d[ctl_wid]          = 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (pend_d != '0) state_d = SPAWN;
            SPAWN:   if (pend_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            pc_q      <= '0;
            overrun_q <= 1'b0;
            active_q  <= NUM_WARPS'(1);
            stalled_q <= '0;
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (w == 0) tmask_q[w] <= NUM_THREADS'(1);
                else        tmask_q[w] <= '0;
            end
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                bar_cnt_q[b]  <= '0;
                bar_mask_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pc_q       <= pc_d;
            overrun_q  <= overrun_d;
            active_q   <= active_d;
            stalled_q  <= stalled_d;
            tmask_q    <= tmask_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_mask_q <= bar_mask_d;
        end
    end

    assign active_warps  = active_q;
    assign stalled_warps = stalled_q;
    assign sched_tmask   = tmask_q[sched_wid];
    assign spawn_valid   = (state_q == SPAWN);
    assign spawn_wid     = low_wid;
    assign spawn_pc      = pc_q;
    assign wspawn_busy   = (state_q != IDLE);
    assign spawn_overrun = overrun_q;

    // A stalled warp cannot issue, so it can never arrive at a barrier again.
    bar_from_stalled_warp: assert property (
        @(posedge clk) disable iff (reset) bar_ev |-> !stalled_q[ctl_wid]
    );

`ifdef WARP_CTL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_spawn_q, perf_spawn_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stalled_q != '0);
        perf_spawn_d = perf_spawn_q + 32'(handshake);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_spawn_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_spawn_q <= perf_spawn_d;
        end
    end

    assign perf_bar_stall_cycles = perf_stall_q;
    assign perf_spawns           = perf_spawn_q;
`endif

endmodule

// File: doc/warp_ctl_receiver.md
Name: warp_ctl_receiver

Overview:
- Consumer end of the warp-control channel driven by the GPU execute unit.
- Applies committed thread-mask changes (tmc), warp-spawn requests (wspawn) and barrier arrivals (bar) to per-warp state.
- Exports active/stalled warp masks and per-warp thread masks to the warp scheduler.
- Serialises spawns to the scheduler one warp per handshake.
- Split/join is out of scope; it belongs to the IPDOM unit.

Parameters:
- NUM_WARPS, 4, number of warps (power of 2, >=2); NW_BITS = log2(NUM_WARPS)
- NUM_THREADS, 4, threads per warp
- NUM_BARRIERS, 4, barrier table entries (power of 2); NB_BITS = log2(NUM_BARRIERS)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ctl_valid  in  1  warp-control event committed this cycle
- ctl_wid  in  NW_BITS  issuing warp
- tmc_valid  in  1  event is tmc
- tmc_tmask  in  NUM_THREADS  new thread mask
- wspawn_valid  in  1  event is wspawn
- wspawn_wmask  in  NUM_WARPS  warps to spawn
- wspawn_pc  in  32  start PC of spawned warps
- bar_valid  in  1  event is barrier arrival
- bar_id  in  NB_BITS  barrier index
- bar_size_m1  in  NW_BITS  participating warps minus one
- active_warps  out  NUM_WARPS  warps eligible to run
- stalled_warps  out  NUM_WARPS  warps blocked on a barrier
- sched_wid  in  NW_BITS  tmask read address
- sched_tmask  out  NUM_THREADS  combinational thread mask of sched_wid
- spawn_valid  out  1  spawn request to scheduler
- spawn_wid  out  NW_BITS  warp being spawned
- spawn_pc  out  32  PC for spawn_wid
- spawn_ready  in  1  scheduler accepts spawn
- wspawn_busy  out  1  spawn FSM not IDLE
- spawn_overrun  out  1  sticky; wspawn arrived while busy

Behaviour:
- The clock is clk. Reset is reset: asynchronous, active-high, a single clock domain.
- Reset values:
  - active_warps = 1 (warp 0 only); stalled_warps = 0.
  - tmask[0] = 1 (thread 0 only); tmask[w>0] = 0.
  - All barrier counts and masks = 0.
  - FSM = IDLE; spawn_valid = 0; spawn_wid = 0; spawn_pc = 0; spawn_overrun = 0.
- Reset mid-spawn or mid-barrier discards all pending state.
- Events:
  - Sampled only when ctl_valid=1. Sub-valids are one-hot.
  - If several sub-valids are set, priority is tmc > wspawn > bar and the rest are ignored.
  - All state updates land at the next clk edge; outputs are registered except sched_tmask.
- tmc:
  - tmask[ctl_wid] <= tmc_tmask.
  - If tmc_tmask == 0, clear active_warps[ctl_wid]; otherwise active is unchanged.
- wspawn FSM, IDLE -> SPAWN:
  - In IDLE, a wspawn loads pend = wspawn_wmask & ~(1<<ctl_wid) & ~active_warps and latches pc.
  - If pend == 0, stay IDLE.
- wspawn FSM, SPAWN:
  - spawn_valid=1; spawn_wid = lowest set bit of pend; spawn_pc = latched pc.
  - On spawn_valid&spawn_ready: set active_warps[spawn_wid], set tmask[spawn_wid]=1, clear that pend bit.
  - Return to IDLE the cycle after the last bit is cleared.
- wspawn while in SPAWN: new bits are ORed into pend, the pc is overwritten, and spawn_overrun is set. spawn_overrun clears only on reset.
- Barrier bar_id, with per-entry count (NW_BITS) and mask (NUM_WARPS):
  - If count == bar_size_m1: release. stalled_warps &= ~mask. count<=0, mask<=0. The arriving warp is not stalled.
  - Otherwise: count++, mask[ctl_wid]<=1, stalled_warps[ctl_wid]<=1.
  - bar_size_m1 == 0 gives immediate release with no stall.
  - A stalled warp cannot issue, so a second arrival from it is illegal; simulation asserts it.
- Same-cycle interactions:
  - A spawn handshake and a tmc on the same warp in one cycle: the tmc value wins for tmask; active is set by the spawn.
  - A release and an arrival on different barriers: both apply.
- sched_tmask = tmask[sched_wid], zero-latency read.

Optional Feature:
- Macro: WARP_CTL_PERF_EN.
- With the macro defined:
  - Adds output perf_bar_stall_cycles [31:0], reset 0.
  - Increments every cycle that stalled_warps != 0. Wraps at 2^32.
  - Adds output perf_spawns [31:0], which increments on each spawn handshake.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release -> active_warps=0001, tmask[0]=0001, stalled=0, spawn_valid=0.
- tmc from wid0 with tmask=1111, then tmc from wid0 with 0000 -> tmask[0]=1111, then active_warps[0]=0.
- wspawn from wid0 with wmask=1111, pc=0x80000100, spawn_ready=1 constantly:
  - spawn_wid sequence is 1,2,3 on consecutive cycles, all with pc 0x80000100.
  - active_warps ends at 1111; wspawn_busy drops after 3 cycles.
- Same wspawn with spawn_ready held low 5 cycles -> spawn_wid stays 1 and spawn_pc stays stable; a second wspawn in this window sets spawn_overrun=1.
- bar id=2, size_m1=2, arrivals from wid 1 then 3 -> stalled=1010; arrival from wid 0 -> stalled=0000 next cycle and the id2 count returns to 0.
- bar size_m1=0 from wid2 -> stalled never set. Also tmc and bar asserted together -> only tmc applied.
